// File: rtl/quad_encoder_ctrl.sv
// Quadrature encoder and pushbutton front end.
// Sync, debounce, x1/x2/x4 decode, short/long press FSM.
module quad_encoder_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PB_CNT_W    = 12,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned LONG_CYCLES = 4096,
  parameter logic [1:0]  IDLE_AB     = 2'b11
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                a,
  input  logic                b,
  input  logic                pb,
  input  logic [1:0]          mode,
  input  logic                wrap,
  input  logic                clr,
  output logic [CNT_W-1:0]    enc_count,
  output logic                dir,
  output logic                step,
  output logic                pb_press,
  output logic                pb_long,
  output logic [PB_CNT_W-1:0] pb_cnt,
  output logic                err
);

  localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] LONG_SAT = TW'(LONG_CYCLES);
  localparam logic [TW-1:0] LONG_PRE = TW'(LONG_CYCLES - 2);
  localparam logic [2:0]    RST3     = {IDLE_AB, 1'b0};

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_PRESSED = 2'b01;
  localparam logic [1:0] S_LONG    = 2'b10;

  // channel order: {a, b, pb}
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    deb;
  logic [DW-1:0] dcnt [3];

  logic [1:0]    ab_prev;
  logic [1:0]    ab_cur;
  logic          pb_deb;
  logic          cw;
  logic          ccw;
  logic          bad;
  logic          qual;
  logic          up;
  logic          dn;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          rel_short;

  assign ab_cur = deb[2:1];
  assign pb_deb = deb[0];

  // Two-stage synchroniser for the raw inputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= RST3;
      s2 <= RST3;
    end else begin
      s1 <= {a, b, pb};
      s2 <= s1;
    end
  end

  // Per-channel debounce: flip only after DEB_CYCLES stable differing samples
  always_ff @(posedge clk) begin
    if (!rstn) begin
      deb <= RST3;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != deb[i]) begin
          if (dcnt[i] == DEB_MAX) begin
            deb[i]  <= s2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Classify the debounced A/B transition and apply resolution
  always_comb begin
    cw   = 1'b0;
    ccw  = 1'b0;
    bad  = 1'b0;
    qual = 1'b0;
    case ({ab_prev, ab_cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: cw  = 1'b1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: ccw = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
      default: ;
    endcase
    case (mode)
      2'b00:   qual = (ab_cur == 2'b00);
      2'b01:   qual = (ab_cur == 2'b00) || (ab_cur == 2'b11);
      default: qual = 1'b1;
    endcase
  end

  assign up = cw & qual;
  assign dn = ccw & qual;

  // Position counter, direction, step pulse and sticky error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ab_prev   <= IDLE_AB;
      enc_count <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ab_prev <= ab_cur;
      step    <= 1'b0;
      if (up || dn) dir <= up;
      if (clr) begin
        enc_count <= '0;
        err       <= 1'b0;
      end else begin
        if (bad) err <= 1'b1;
        if (up && (wrap || enc_count != '1)) begin
          enc_count <= enc_count + 1'b1;
          step      <= 1'b1;
        end else if (dn && (wrap || enc_count != '0)) begin
          enc_count <= enc_count - 1'b1;
          step      <= 1'b1;
        end
      end
    end
  end

  assign rel_short = (state == S_PRESSED) && !pb_deb;

  // Pushbutton FSM: short press on release, long press once per hold
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      timer    <= '0;
      pb_press <= 1'b0;
      pb_long  <= 1'b0;
      pb_cnt   <= '0;
    end else begin
      pb_press <= 1'b0;
      pb_long  <= 1'b0;
      if (timer != LONG_SAT) timer <= timer + 1'b1;
      case (state)
        S_IDLE: begin
          if (pb_deb) begin
            state <= S_PRESSED;
            timer <= '0;
          end
        end
        S_PRESSED: begin
          if (!pb_deb) begin
            state    <= S_IDLE;
            pb_press <= 1'b1;
          end else if (timer == LONG_PRE) begin
            state   <= S_LONG;
            pb_long <= 1'b1;
          end
        end
        S_LONG: begin
          if (!pb_deb) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (clr) pb_cnt <= '0;
      else if (rel_short) pb_cnt <= pb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Bench for quad_encoder_ctrl.
// Scoreboard queues hold expected pulse payloads.
module tb_quad_encoder_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 1000;
  localparam int MAXC = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a;
  logic        b;
  logic        pb;
  logic [1:0]  mode;
  logic        wrap;
  logic        clr;
  logic [3:0]  enc_count;
  logic        dir;
  logic        step;
  logic        pb_press;
  logic        pb_long;
  logic [11:0] pb_cnt;
  logic        err;

  quad_encoder_ctrl #(
    .CNT_W(4), .PB_CNT_W(12), .DEB_CYCLES(DEB),
    .LONG_CYCLES(LONG), .IDLE_AB(2'b11)
  ) dut (
    .clk(clk), .rstn(rstn), .a(a), .b(b), .pb(pb),
    .mode(mode), .wrap(wrap), .clr(clr),
    .enc_count(enc_count), .dir(dir), .step(step),
    .pb_press(pb_press), .pb_long(pb_long),
    .pb_cnt(pb_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int step_q [$];
  int press_q [$];
  int long_q [$];

  int         m_cnt = 0;
  int         m_dir = 0;
  int         m_err = 0;
  int         m_pbc = 0;
  logic [1:0] cur_ab = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Scoreboard side: compare each pulse against the oldest expectation
  always @(negedge clk) begin
    if (rstn) begin
      if (step) begin
        if (step_q.size() == 0) check("step_unexp", 1, 0);
        else check("step_cnt", enc_count, step_q.pop_front());
      end
      if (pb_press) begin
        if (press_q.size() == 0) check("press_unexp", 1, 0);
        else check("press_cnt", pb_cnt, press_q.pop_front());
      end
      if (pb_long) begin
        if (long_q.size() == 0) check("long_unexp", 1, 0);
        else check("long_cyc", cyc, long_q.pop_front());
      end
    end
  end

  task automatic move(input logic [1:0] nab);
    int  d;
    logic q;
    d = (pos(nab) - pos(cur_ab)) & 3;
    if (mode == 2'b00)      q = (nab == 2'b00);
    else if (mode == 2'b01) q = (nab == 2'b00) || (nab == 2'b11);
    else                    q = 1'b1;
    if (d == 2) m_err = 1;
    else if (d != 0 && q) begin
      m_dir = (d == 1) ? 1 : 0;
      if (d == 1) begin
        if (m_cnt < MAXC) begin m_cnt++; step_q.push_back(m_cnt); end
        else if (wrap) begin m_cnt = 0; step_q.push_back(m_cnt); end
      end else begin
        if (m_cnt > 0) begin m_cnt--; step_q.push_back(m_cnt); end
        else if (wrap) begin m_cnt = MAXC; step_q.push_back(m_cnt); end
      end
    end
    a = nab[1];
    b = nab[0];
    cur_ab = nab;
    tick(DEB + 4);
    check("cnt", enc_count, m_cnt);
    check("dir", dir, m_dir);
    check("err", err, m_err);
    check("step_pend", step_q.size(), 0);
  endtask

  function automatic logic [1:0] cw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic rot(input int n, input bit cwd);
    for (int i = 0; i < n; i++)
      move(cwd ? cw_next(cur_ab) : ccw_next(cur_ab));
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_cnt = 0;
    m_err = 0;
    m_pbc = 0;
    tick(1);
    check("clr_cnt", enc_count, 0);
    check("clr_err", err, 0);
    check("clr_pbc", pb_cnt, 0);
  endtask

  task automatic press(input int hold);
    int c;
    c = cyc;
    if (hold + 1 < LONG) press_q.push_back(++m_pbc);
    else long_q.push_back(c + 2 + DEB + LONG);
    pb = 1'b1;
    tick(hold);
    pb = 1'b0;
    tick(DEB + 4);
    check("pb_cnt", pb_cnt, m_pbc);
    check("press_pend", press_q.size(), 0);
    check("long_pend", long_q.size(), 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_cnt"}, enc_count, 0);
    check({pfx, "_dir"}, dir, 0);
    check({pfx, "_step"}, step, 0);
    check({pfx, "_press"}, pb_press, 0);
    check({pfx, "_long"}, pb_long, 0);
    check({pfx, "_pbc"}, pb_cnt, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  initial begin
    rstn = 1'b0;
    a = 1'b1;
    b = 1'b1;
    pb = 1'b0;
    mode = 2'b10;
    wrap = 1'b1;
    clr = 1'b0;
    tick(3);
    check_zero("rst");
    rstn = 1'b1;
    tick(2);

    rot(8, 1'b1);
    rot(3, 1'b0);

    do_clr();
    mode = 2'b00;
    rot(4, 1'b1);
    mode = 2'b01;
    rot(4, 1'b1);
    mode = 2'b10;
    rot(4, 1'b1);

    rot(8, 1'b1);
    rot(1, 1'b1);
    rot(1, 1'b0);
    wrap = 1'b0;
    rot(1, 1'b1);
    do_clr();
    rot(1, 1'b0);

    a = ~cur_ab[1];
    tick(3);
    a = cur_ab[1];
    tick(DEB + 6);
    check("glitch_cnt", enc_count, m_cnt);
    check("glitch_err", err, 0);

    move(~cur_ab);
    do_clr();

    press(100);
    press(1500);

    pb = 1'b1;
    tick(DEB + 2 + 500);
    rstn = 1'b0;
    pb = 1'b0;
    a = 1'b1;
    b = 1'b1;
    cur_ab = 2'b11;
    tick(1);
    rstn = 1'b1;
    m_cnt = 0;
    m_dir = 0;
    m_err = 0;
    m_pbc = 0;
    tick(LONG + 20);
    check_zero("midrst");
    check("q_step", step_q.size(), 0);
    check("q_press", press_q.size(), 0);
    check("q_long", long_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quad_encoder_ctrl.md
# quad_encoder_ctrl

Parametrised quadrature encoder and pushbutton front end. It is the successor of the fixed 4-bit rotary encoder counter and sits directly behind `ui_in` in the top level. Each raw input is synchronised and debounced. The block decodes A/B into a configurable-resolution up/down count (wrap or saturate) and classifies pushbutton activity into short presses, counted, and long presses. A sticky error flag reports illegal quadrature jumps.

## Interface
- `CNT_W`, 8: width of the encoder count.
- `PB_CNT_W`, 12: width of the short-press counter.
- `DEB_CYCLES`, 16: consecutive stable cycles needed to accept a new level. Minimum 2.
- `LONG_CYCLES`, 4096: hold time that qualifies a long press. Must be greater than `DEB_CYCLES`.
- `IDLE_AB`, 2'b11: reset value of the synchroniser and debounced `{a,b}`; matches the pulled-up idle level.

- `clk` in 1: single clock.
- `rstn` in 1: synchronous, active-low reset.
- `a` in 1: raw encoder channel A, asynchronous.
- `b` in 1: raw encoder channel B, asynchronous.
- `pb` in 1: raw pushbutton, asynchronous, active high = pressed.
- `mode` in 2: resolution. 00 = x1, 01 = x2, 1x = x4.
- `wrap` in 1: 1 = count modulo 2^CNT_W; 0 = saturate at 0 and 2^CNT_W-1.
- `clr` in 1: synchronous clear of `enc_count`, `pb_cnt` and `err`.
- `enc_count` out CNT_W: current position.
- `dir` out 1: direction of the last qualified transition. 1 = CW.
- `step` out 1: one-cycle pulse when `enc_count` changed this cycle.
- `pb_press` out 1: one-cycle pulse on release of a short press.
- `pb_long` out 1: one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `pb_cnt` out PB_CNT_W: number of short presses, wraps.
- `err` out 1: sticky; set on an illegal A/B transition.

## Operation
- **Synchronisers.** `a`, `b` and `pb` each pass through a 2-FF synchroniser.
- **Debouncers.** Each input has its own debouncer.
  - The counter increments while the sync output differs from the debounced level and resets to 0 while it is equal.
  - When the counter reaches DEB_CYCLES-1 and the input still differs, the debounced level flips and the counter returns to 0.
  - Any pulse shorter than DEB_CYCLES cycles is rejected.
- **Quadrature decode.** The decoder compares the previous and current debounced `{A,B}`.
  - CW sequence: 00→10→11→01→00. The reverse sequence is CCW.
  - A transition where both bits change (including A and B debouncers flipping in the same cycle) is illegal. It sets `err` and causes no count and no `dir` update.
- **Qualification by `mode`.**
  - x4: every legal transition counts.
  - x2: only transitions entering 00 or 11 count.
  - x1: only transitions entering 00 count.
  - `mode` is sampled every cycle; changing it mid-rotation takes effect on the next transition.
- **Count update.** A qualified CW transition adds 1 and a qualified CCW transition subtracts 1.
  - `dir` updates on every qualified transition.
  - With `wrap`=0 at a limit, `enc_count` holds, `step` stays 0 and `dir` still updates.
  - With `wrap`=1: 2^CNT_W-1 +1 → 0, and 0 -1 → 2^CNT_W-1.
- **Pushbutton FSM.** States: IDLE, PRESSED, LONG. A hold timer saturates at LONG_CYCLES.
  - IDLE → PRESSED on the debounced `pb` rising; the timer clears.
  - PRESSED → LONG when the timer reaches LONG_CYCLES-1; `pb_long` pulses once.
  - PRESSED → IDLE on release; `pb_press` pulses and `pb_cnt` increments.
  - LONG → IDLE on release, with no `pb_press` and no count.
- **`clr` priority.** `clr` beats a same-cycle count or press event: the result is 0, `step`=0, and `pb_press` still pulses. `clr` does not reset the FSM, the debouncers or the synchronisers.

## Timing
- **Reset values** (`rstn` sampled low at a clk edge):
  - Outputs: `enc_count`=0, `dir`=0, `step`=0, `pb_press`=0, `pb_long`=0, `pb_cnt`=0, `err`=0.
  - Internal: debounced/previous `{A,B}`=IDLE_AB, debounced `pb`=0, FSM=IDLE, all counters 0.
  - Reset mid-rotation or mid-press abandons that event. No pulse is emitted on the cycle reset releases.
- **Latency.** Raw level change first sampled at edge N, then held stable:
  - The debounced level flips at edge N+1+DEB_CYCLES.
  - `enc_count`, `step`, `dir`, `err`, `pb_press` and the PB FSM state update at edge N+2+DEB_CYCLES.
  - `pb_long` asserts at the edge where the hold timer reaches LONG_CYCLES-1.
- **Pulse width.** `step`, `pb_press` and `pb_long` are high for exactly one cycle and are registered outputs.
- **Throughput.** Back-to-back transitions are accepted one per debounced edge; no events are lost or merged.

## Test plan
- **x4 rotation.** `mode`=10, DEB_CYCLES=4. Drive 8 clean CW transitions from 11 → `enc_count`=8, 8 `step` pulses, `dir`=1. Then 3 CCW transitions → `enc_count`=5, `dir`=0.
- **x1 and x2 resolution.** One full CW cycle (4 transitions) → +1 in x1, +2 in x2, +4 in x4.
- **Wrap and saturate.** CNT_W=4, `wrap`=1: at 15, one CW count → 0, then one CCW count → 15. With `wrap`=0: at 15, one CW count → 15 with no `step`; at 0, one CCW count → 0.
- **Glitch and illegal jump.** A 3-cycle pulse on `a` with DEB_CYCLES=4 → no change. Toggle `a` and `b` in the same cycle and hold them → `err`=1, count unchanged. `clr` → `err`=0, `enc_count`=0.
- **Pushbutton.** A 100-cycle press with LONG_CYCLES=1000 → one `pb_press` on release and `pb_cnt`=1. A 1500-cycle hold → one `pb_long` at the required cycle, no `pb_press`, `pb_cnt` still 1.
- **Reset mid-hold.** Assert `rstn`=0 for one cycle during a press at timer 500, then release `pb` → no `pb_press` or `pb_long`, and all outputs are 0 after reset.
